vga_timing_ctrl: RTL and testbench
==================================

VGA_TIMING_CTRL -- requirements
Module: vga_timing_ctrl

Interface
REQ-001 Parameter: DIV, default 4, system clocks per pixel tick (100 MHz to 25 MHz).
REQ-002 Parameter: H_VIS/H_FP/H_SYNC/H_BP, defaults 640/16/96/48, horizontal timing in pixels.
REQ-003 Parameter: V_VIS/V_FP/V_SYNC/V_BP, defaults 480/10/2/33, vertical timing in lines.
REQ-004 Port: clk, input, 1, the single system clock; all logic SHALL be on its rising edge.
REQ-005 Port: rst_n, input, 1, asynchronous active-low reset.
REQ-006 Port: stage_in, input, 1, menu/game select from the game FSM.
REQ-007 Port: board_blank_in, input, 81, per-cell user-entered flags.
REQ-008 Port: board_in, input, 324, 81 cells x 4-bit digit.
REQ-009 Port: upd_req, input, 1, level request to shadow new stage/board data.
REQ-010 Port: upd_ack, output, 1, one-clk acknowledge of a completed shadow load.
REQ-011 Port: pix_tick, output, 1, one-clk pulse every DIV clocks.
REQ-012 Port: h_cnt, output, 10, horizontal pixel counter.
REQ-013 Port: v_cnt, output, 10, vertical line counter.
REQ-014 Port: hsync, output, 1, active-low horizontal sync.
REQ-015 Port: vsync, output, 1, active-low vertical sync.
REQ-016 Port: valid, output, 1, high inside the 640x480 visible area.
REQ-017 Port: frame_start, output, 1, one-clk pulse when counters wrap to (0,0).
REQ-018 Port: stage_out / board_blank_out / board_out, output, 1/81/324, tear-free shadow copies consumed by the pixel generator.

Function
REQ-019 A modulo-DIV divider SHALL assert pix_tick on the clk where the divider equals DIV-1.
REQ-020 On pix_tick, h_cnt SHALL increment and wrap from 799 to 0; on that wrap, v_cnt SHALL increment and wrap from 524 to 0.
REQ-021 Counters, hsync, vsync and valid SHALL change only on pix_tick; they SHALL be registered and mutually aligned.
REQ-022 hsync SHALL be 0 exactly for h_cnt 656..751; vsync SHALL be 0 exactly for v_cnt 490..491.
REQ-023 valid SHALL be 1 iff h_cnt<640 and v_cnt<480.
REQ-024 frame_start SHALL pulse for one clk on the pix_tick that loads (0,0).
REQ-025 Shadow load point SHALL be the pix_tick that loads h_cnt=0, v_cnt=480 (start of vblank).
REQ-026 If upd_req=1 at the load point, all three shadow registers SHALL load from their inputs and upd_ack SHALL pulse for exactly one clk; otherwise the shadows SHALL hold.
REQ-027 A request raised during the visible area SHALL wait for the next load point; the requester holds inputs stable until upd_ack.
REQ-028 If upd_req stays high after upd_ack, one reload per frame SHALL occur; there SHALL be no other load path.

Reset
REQ-029 rst_n=0 SHALL immediately force: divider 0, h_cnt 0, v_cnt 0, hsync 1, vsync 1, valid 0, pix_tick 0, frame_start 0, upd_ack 0, all shadow outputs 0.
REQ-030 After release, the first pix_tick SHALL load (1,0) with valid=1; a reset mid-frame SHALL abandon the frame and any pending request, with no upd_ack.

Configuration
REQ-031 Macro SYNC_DELAY_EN: when defined, hsync, vsync and valid SHALL be delayed by one extra pix_tick relative to h_cnt/v_cnt, matching the one-cycle block-memory read latency downstream.
REQ-032 Without SYNC_DELAY_EN, hsync, vsync and valid SHALL be aligned with h_cnt/v_cnt per REQ-021.
REQ-033 The delay stage SHALL reset to hsync=1, vsync=1, valid=0.

Verification
REQ-034 Reset release, 8 clks -> pix_tick at clks 4 and 8; h_cnt=2, v_cnt=0; vsync=1.
REQ-035 Run one line -> hsync low for exactly 96 pix_ticks, falling on h_cnt=656 (on 657 with SYNC_DELAY_EN).
REQ-036 Run two frames -> frame_start spacing exactly 1,680,000 clks; vsync low for exactly 1600 pix_ticks per frame.
REQ-037 upd_req=1 at v_cnt=100 with board_in cell0=4'h5 -> single upd_ack at (0,480); board_out[3:0]=5; board_out unchanged before that point.
REQ-038 upd_req pending at v_cnt=300, then rst_n pulsed -> counters 0, shadows 0, no upd_ack until the next load point after re-request.

Source files
------------

// File: rtl/vga_timing_ctrl.sv
// VGA 640x480 timing generator with tear-free shadowing of the board state.
// Optional macro SYNC_DELAY_EN delays hsync/vsync/valid by one pixel tick.
module vga_timing_ctrl #(
    parameter int DIV    = 4,
    parameter int H_VIS  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_VIS  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         stage_in,
    input  logic [80:0]  board_blank_in,
    input  logic [323:0] board_in,
    input  logic         upd_req,
    output logic         upd_ack,
    output logic         pix_tick,
    output logic [9:0]   h_cnt,
    output logic [9:0]   v_cnt,
    output logic         hsync,
    output logic         vsync,
    output logic         valid,
    output logic         frame_start,
    output logic         stage_out,
    output logic [80:0]  board_blank_out,
    output logic [323:0] board_out
);

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [9:0] H_LAST = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_VIS_L = 10'(H_VIS);
    localparam logic [9:0] V_VIS_L = 10'(V_VIS);
    localparam logic [9:0] H_SS = 10'(H_VIS + H_FP);
    localparam logic [9:0] H_SE = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] V_SS = 10'(V_VIS + V_FP);
    localparam logic [9:0] V_SE = 10'(V_VIS + V_FP + V_SYNC);

    logic [DW-1:0]  div_q, div_d;
    logic [9:0]     h_cnt_q, h_cnt_d;
    logic [9:0]     v_cnt_q, v_cnt_d;
    logic           hs_q, hs_d;
    logic           vs_q, vs_d;
    logic           vld_q, vld_d;
    logic           fs_q, fs_d;
    logic           ack_q, ack_d;
    logic           stage_q, stage_d;
    logic [80:0]    blank_q, blank_d;
    logic [323:0]   board_q, board_d;

    logic           tick;
    logic           load;
    logic [9:0]     h_nxt;
    logic [9:0]     v_nxt;

    assign tick = (div_q == DIV_LAST);

    always_comb begin
        div_d   = tick ? '0 : div_q + DW'(1);
        h_nxt   = (h_cnt_q == H_LAST) ? 10'd0 : h_cnt_q + 10'd1;
        v_nxt   = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            v_nxt = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
        end
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        hs_d    = hs_q;
        vs_d    = vs_q;
        vld_d   = vld_q;
        // Sync/valid are decoded from the next count so they stay aligned.
        if (tick) begin
            h_cnt_d = h_nxt;
            v_cnt_d = v_nxt;
            hs_d    = !((h_nxt >= H_SS) && (h_nxt < H_SE));
            vs_d    = !((v_nxt >= V_SS) && (v_nxt < V_SE));
            vld_d   = (h_nxt < H_VIS_L) && (v_nxt < V_VIS_L);
        end
        fs_d    = tick && (h_nxt == 10'd0) && (v_nxt == 10'd0);
        load    = tick && (h_nxt == 10'd0) && (v_nxt == V_VIS_L)
                  && upd_req;
        ack_d   = load;
        stage_d = load ? stage_in       : stage_q;
        blank_d = load ? board_blank_in : blank_q;
        board_d = load ? board_in       : board_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q   <= '0;
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            vld_q   <= 1'b0;
            fs_q    <= 1'b0;
            ack_q   <= 1'b0;
            stage_q <= 1'b0;
            blank_q <= '0;
            board_q <= '0;
        end else begin
            div_q   <= div_d;
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            vld_q   <= vld_d;
            fs_q    <= fs_d;
            ack_q   <= ack_d;
            stage_q <= stage_d;
            blank_q <= blank_d;
            board_q <= board_d;
        end
    end

`ifdef SYNC_DELAY_EN
    logic hs_dly_q, hs_dly_d;
    logic vs_dly_q, vs_dly_d;
    logic vld_dly_q, vld_dly_d;

    // Extra pixel of latency to line up with the block-RAM read downstream.
    always_comb begin
        hs_dly_d  = tick ? hs_q  : hs_dly_q;
        vs_dly_d  = tick ? vs_q  : vs_dly_q;
        vld_dly_d = tick ? vld_q : vld_dly_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_dly_q  <= 1'b1;
            vs_dly_q  <= 1'b1;
            vld_dly_q <= 1'b0;
        end else begin
            hs_dly_q  <= hs_dly_d;
            vs_dly_q  <= vs_dly_d;
            vld_dly_q <= vld_dly_d;
        end
    end

    assign hsync = hs_dly_q;
    assign vsync = vs_dly_q;
    assign valid = vld_dly_q;
`else
    assign hsync = hs_q;
    assign vsync = vs_q;
    assign valid = vld_q;
`endif

    assign pix_tick        = tick;
    assign h_cnt           = h_cnt_q;
    assign v_cnt           = v_cnt_q;
    assign frame_start     = fs_q;
    assign upd_ack         = ack_q;
    assign stage_out       = stage_q;
    assign board_blank_out = blank_q;
    assign board_out       = board_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed bench for vga_timing_ctrl on a shrunken raster (25x15 pixels).
// Closed-form position model plus a queue of expected shadow loads.
module tb_vga_timing_ctrl;

    localparam int DIV = 4;
    localparam int HV = 16, HF = 2, HS = 4, HB = 3;
    localparam int VV = 8, VF = 2, VS = 2, VB = 3;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int F  = HT * VT;
`ifdef SYNC_DELAY_EN
    localparam int DLY = 1;
`else
    localparam int DLY = 0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         stage_in;
    logic [80:0]  board_blank_in;
    logic [323:0] board_in;
    logic         upd_req;
    logic         upd_ack, pix_tick, hsync, vsync, valid, frame_start;
    logic [9:0]   h_cnt, v_cnt;
    logic         stage_out;
    logic [80:0]  board_blank_out;
    logic [323:0] board_out;

    vga_timing_ctrl #(
        .DIV(DIV), .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .stage_in(stage_in),
        .board_blank_in(board_blank_in), .board_in(board_in),
        .upd_req(upd_req), .upd_ack(upd_ack), .pix_tick(pix_tick),
        .h_cnt(h_cnt), .v_cnt(v_cnt), .hsync(hsync), .vsync(vsync),
        .valid(valid), .frame_start(frame_start), .stage_out(stage_out),
        .board_blank_out(board_blank_out), .board_out(board_out)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int ncyc;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ncyc <= 0;
        else        ncyc <= ncyc + 1;
    end

    logic [405:0] sb[$];
    logic [405:0] sh_exp;
    logic         hold_req;
    logic         ack_seen;
    logic         have_fs;
    int           last_fs, hs_low, vs_low;
    logic         prev_hs, hl_active;
    int           hl_cnt;

    task automatic chk(input string tag, input logic [405:0] obs,
                       input logic [405:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
            $error("check %s differs", tag);
        end
    endtask

    task automatic clear_stats();
        have_fs   = 1'b0;
        hs_low    = 0;
        vs_low    = 0;
        prev_hs   = 1'b1;
        hl_active = 1'b0;
        hl_cnt    = 0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            int t, ph, pos, eh, ev, s, sp, sh, sv;
            logic ehs, evs, evld, etk, efs, eack;
            @(negedge clk);
            t   = ncyc / DIV;
            ph  = ncyc % DIV;
            pos = t % F;
            eh  = pos % HT;
            ev  = pos / HT;
            etk = (ph == DIV - 1);
            s   = t - DLY;
            if (s <= 0) begin
                ehs = 1'b1; evs = 1'b1; evld = 1'b0;
            end else begin
                sp   = s % F;
                sh   = sp % HT;
                sv   = sp / HT;
                ehs  = !(sh >= HV + HF && sh < HV + HF + HS);
                evs  = !(sv >= VV + VF && sv < VV + VF + VS);
                evld = (sh < HV) && (sv < VV);
            end
            efs  = (ph == 0) && (t > 0) && (pos == 0);
            eack = (ph == 0) && (t > 0) && (pos == VV * HT) && upd_req;
            if (eack && sb.size() > 0) sh_exp = sb.pop_front();
            chk("timing", {h_cnt, v_cnt, hsync, vsync, valid,
                           pix_tick, frame_start, upd_ack},
                {10'(eh), 10'(ev), ehs, evs, evld, etk, efs, eack});
            chk("shadow", {stage_out, board_blank_out, board_out}, sh_exp);
            if (upd_ack) ack_seen = 1'b1;
            if (frame_start) begin
                if (have_fs) begin
                    chk("fs_spacing", ncyc - last_fs, F * DIV);
                    chk("hs_low_frame", hs_low, VT * HS);
                    chk("vs_low_frame", vs_low, HT * VS);
                end
                have_fs = 1'b1;
                last_fs = ncyc;
                hs_low  = 0;
                vs_low  = 0;
            end
            if (ph == 0 && !hsync) hs_low++;
            if (ph == 0 && !vsync) vs_low++;
            if (prev_hs && !hsync) begin
                chk("hs_fall_h", h_cnt, HV + HF + DLY);
                hl_active = 1'b1;
                hl_cnt    = 0;
            end
            if (!prev_hs && hsync && hl_active) chk("hs_line_low", hl_cnt, HS);
            if (ph == 0 && !hsync) hl_cnt++;
            prev_hs = hsync;
            if (eack) begin
                if (hold_req) sb.push_back({stage_in, board_blank_in, board_in});
                else          upd_req = 1'b0;
            end
        end
    endtask

    task automatic run_until_v(input int v);
        int n = 0;
        while (v_cnt !== 10'(v) && n < 4 * F * DIV) begin
            run(1);
            n++;
        end
        chk("wait_v", v_cnt, v);
    endtask

    task automatic run_until_ack();
        int n = 0;
        ack_seen = 1'b0;
        while (!ack_seen && n < 2 * F * DIV) begin
            run(1);
            n++;
        end
        chk("ack_wait", ack_seen, 1'b1);
    endtask

    task automatic new_data(input logic [3:0] cell0);
        for (int i = 0; i < 81; i++) begin
            board_in[i*4 +: 4]  = 4'($urandom_range(0, 9));
            board_blank_in[i]   = 1'($urandom);
        end
        board_in[3:0] = cell0;
        stage_in      = ~stage_in;
    endtask

    task automatic request();
        upd_req = 1'b1;
        sb.push_back({stage_in, board_blank_in, board_in});
    endtask

    localparam logic [25:0] RST_VEC = {10'd0, 10'd0, 1'b1, 1'b1, 1'b0,
                                       1'b0, 1'b0, 1'b0};

    initial begin
        rst_n          = 1'b0;
        upd_req        = 1'b0;
        stage_in       = 1'b0;
        board_in       = '0;
        board_blank_in = '0;
        hold_req       = 1'b0;
        sh_exp         = '0;
        ack_seen       = 1'b0;
        last_fs        = 0;
        clear_stats();
        repeat (3) @(negedge clk);
        chk("reset_vec", {h_cnt, v_cnt, hsync, vsync, valid,
                          pix_tick, frame_start, upd_ack}, RST_VEC);
        chk("reset_shadow", {stage_out, board_blank_out, board_out}, '0);
        rst_n = 1'b1;

        run(8);
        chk("h_after8", h_cnt, 2);
        chk("v_after8", v_cnt, 0);
        chk("vs_after8", vsync, 1'b1);

        run_until_v(3);
        new_data(4'h5);
        request();
        run_until_ack();
        chk("ack_pos", {h_cnt, v_cnt}, {10'd0, 10'(VV)});
        chk("cell0", board_out[3:0], 4'h5);

        run(2 * F * DIV + 40);

        run_until_v(2);
        new_data(4'h7);
        hold_req = 1'b1;
        request();
        run_until_ack();
        run_until_ack();
        chk("cell0_hold", board_out[3:0], 4'h7);
        run_until_v(2);
        upd_req  = 1'b0;
        hold_req = 1'b0;
        sb.delete();
        run(F * DIV);

        run_until_v(3);
        new_data(4'h9);
        request();
        run(20);
        rst_n   = 1'b0;
        upd_req = 1'b0;
        sb.delete();
        sh_exp  = '0;
        clear_stats();
        #1;
        chk("midrst_vec", {h_cnt, v_cnt, hsync, vsync, valid,
                           pix_tick, frame_start, upd_ack}, RST_VEC);
        chk("midrst_shadow", {stage_out, board_blank_out, board_out}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        run(F * DIV + 20);
        chk("no_ack_shadow", board_out, '0);

        run_until_v(4);
        request();
        run_until_ack();
        chk("cell0_rereq", board_out[3:0], 4'h9);
        run(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
